chan_fifo_writer: RTL and testbench
===================================

Name: chan_fifo_writer

Overview:
RX-side counterpart of the per-channel TX FIFO reader. Collects rx_strobe-qualified I/Q samples and packetises them into the in-band packet format: header word, timestamp word, then PAYLOAD_WORDS sample words. Writes each packet into the channel's RX packet FIFO for the USB/host side. The block sits between the RX DSP chain output and the RX FIFO write port. A packet starts only when the FIFO has room for a whole packet; otherwise samples are dropped and flagged.

Parameters:
PAYLOAD_WORDS, 126, sample words per packet (payload bytes = 4*PAYLOAD_WORDS, must be ≤ 511)
FIFO_DEPTH, 512, RX FIFO depth in 32-bit words
USEDW_W, 9, width of fifo_used
CHANNEL, 0, 5-bit channel number placed in the header

Ports:
rx_clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  channel receive enable
rx_strobe  in  1  one-cycle sample-valid pulse; pulses are ≥4 cycles apart (interface requirement)
rx_i  in  16  I sample, valid with rx_strobe
rx_q  in  16  Q sample, valid with rx_strobe
timestamp_clock  in  32  current time
rssi  in  32  current RSSI
fifo_used  in  USEDW_W  RX FIFO occupancy in words
wrreq  out  1  FIFO write enable (registered)
wrdata  out  32  FIFO write data (registered)
overrun  out  1  one-cycle pulse per dropped sample
debug  out  15  {7'd0, wrreq, overrun, state[2:0], enable, rx_strobe, rx_clock}

Behaviour:
- Reset is synchronous and active-high on rx_clock. Reset values: wrreq=0, wrdata=0, overrun=0, state=IDLE, word count=0, ovr_pending=0, sob_pending=1.
- Sample word = {rx_q, rx_i}, the same packing the TX reader unpacks.
- Header word:
  - [31] ovr_pending
  - [28] sob_pending (start of burst)
  - [20:16] CHANNEL
  - [14:9] rssi[5:0]
  - [8:0] 4*PAYLOAD_WORDS
  - all other bits 0
- Space test: space_ok = (FIFO_DEPTH - fifo_used) ≥ PAYLOAD_WORDS+2. Compute in USEDW_W+1 bits; no wrap.
- States:
  - IDLE:
    - On rx_strobe & enable & space_ok: latch sample into hold register, latch timestamp_clock, next cycle drive wrreq=1 with the header word; go to TIMESTAMP.
    - On rx_strobe & enable & !space_ok: overrun=1 for one cycle, ovr_pending=1, sample dropped.
    - enable low: sob_pending=1.
  - TIMESTAMP: write the latched timestamp word (first-sample time); go to FIRST.
  - FIRST: write the held sample; count=1; clear ovr_pending and sob_pending; go to DATA.
  - DATA:
    - Each rx_strobe writes the sample the following cycle; count++.
    - When count reaches PAYLOAD_WORDS, go to IDLE. IDLE may accept a strobe on the next cycle.
    - enable low → PAD.
  - PAD: write 32'd0 each cycle until count = PAYLOAD_WORDS, then IDLE with sob_pending=1. Packets are always full length.
- Latency: strobe at cycle T in IDLE → header at T+1, timestamp at T+2, first sample at T+3. In DATA, strobe at S → write at S+1.
- wrreq is never high except for a header, timestamp, sample or pad word. Each packet is exactly PAYLOAD_WORDS+2 writes.
- rx_strobe with enable low in IDLE: ignored, no overrun.
- Reset mid-packet: wrreq=0 on the next cycle and state=IDLE. The partial packet is discarded because the FIFO shares the reset.
- fifo_used is checked only at packet start. The space reservation guarantees no mid-packet overflow.

Decomposition:
- Shared package `inband_pkt` holds:
  - header bit positions (OVERRUN=31, STARTOFBURST=28, ENDOFBURST=27, RSSI_FLAG=26, MF_FLAG=25, CHAN=20:16, RSSI=14:9, PAYLOAD=8:0)
  - state encodings
  - the QI16 sample-format constant
- The TX reader uses the same package.
- No sub-module; the space comparator is inline.

Test Plan:
1. Empty FIFO (fifo_used=0), enable=1, PAYLOAD_WORDS=4, 4 strobes 4 cycles apart with samples {q,i}=0x0002_0001.. and timestamp_clock=100 at the first strobe → 6 writes: header 0x1000_0010 (SOB, CHANNEL=0, rssi=0, len 16), 0x0000_0064, then 4 samples in order; first sample at T+3.
2. fifo_used=FIFO_DEPTH-5, strobe (need 6 words) → no wrreq, overrun pulse. Then fifo_used=0 and strobe → header bit31=1. The next packet's header has bit31=0.
3. Second consecutive packet without an enable drop → header bit28=0. After enable toggles 1→0→1 → bit28=1.
4. enable dropped after 2 of 4 samples → 2 zero pad words written on consecutive cycles; total 6 writes; back to IDLE.
5. reset asserted during TIMESTAMP → wrreq=0 on the next cycle, debug state=0. A new strobe after reset starts a clean packet with SOB=1 and OVR=0.
6. CHANNEL=5, rssi=0x2A → header [20:16]=5, [14:9]=0x2A.

Source files
------------

// File: rtl/inband_pkt.sv
// In-band packet definitions shared by the per-channel TX FIFO reader and RX FIFO writer.
package inband_pkt;

    localparam int unsigned HDR_OVERRUN      = 31;
    localparam int unsigned HDR_STARTOFBURST = 28;
    localparam int unsigned HDR_ENDOFBURST   = 27;
    localparam int unsigned HDR_RSSI_FLAG    = 26;
    localparam int unsigned HDR_MF_FLAG      = 25;
    localparam int unsigned HDR_CHAN_LSB     = 16;
    localparam int unsigned HDR_CHAN_W       = 5;
    localparam int unsigned HDR_RSSI_LSB     = 9;
    localparam int unsigned HDR_RSSI_W       = 6;
    localparam int unsigned HDR_PAYLOAD_LSB  = 0;
    localparam int unsigned HDR_PAYLOAD_W    = 9;

    localparam int unsigned WORD_W = 32;

    // Sample format code for 16-bit interleaved I/Q words
    localparam logic [3:0] FMT_QI16 = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TIMESTAMP = 3'd1,
        ST_FIRST     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PAD       = 3'd4
    } pkt_state_t;

    // One payload word: Q in the upper half, I in the lower half
    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_sample_t;

    function automatic logic [WORD_W-1:0] make_header(
        input logic                     ovr,
        input logic                     sob,
        input logic [HDR_CHAN_W-1:0]    chan,
        input logic [HDR_RSSI_W-1:0]    rssi6,
        input logic [HDR_PAYLOAD_W-1:0] len_bytes
    );
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_OVERRUN]                            = ovr;
        h[HDR_STARTOFBURST]                       = sob;
        h[HDR_CHAN_LSB +: HDR_CHAN_W]             = chan;
        h[HDR_RSSI_LSB +: HDR_RSSI_W]             = rssi6;
        h[HDR_PAYLOAD_LSB +: HDR_PAYLOAD_W]       = len_bytes;
        return h;
    endfunction

endpackage

// File: rtl/chan_fifo_writer.sv
// RX channel packetiser: wraps strobed I/Q samples into header/timestamp/payload packets
// and writes them to the RX packet FIFO, dropping samples when a whole packet won't fit.
module chan_fifo_writer
    import inband_pkt::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 126,
    parameter int unsigned FIFO_DEPTH    = 512,
    parameter int unsigned USEDW_W       = 9,
    parameter int unsigned CHANNEL       = 0
) (
    input  logic               rx_clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               rx_strobe,
    input  logic [15:0]        rx_i,
    input  logic [15:0]        rx_q,
    input  logic [31:0]        timestamp_clock,
    input  logic [31:0]        rssi,
    input  logic [USEDW_W-1:0] fifo_used,
    output logic               wrreq,
    output logic [31:0]        wrdata,
    output logic               overrun,
    output logic [14:0]        debug
);

    localparam int unsigned CNT_W  = $clog2(PAYLOAD_WORDS + 1);
    localparam int unsigned FREE_W = USEDW_W + 1;

    localparam logic [CNT_W-1:0]         LAST_CNT  = CNT_W'(PAYLOAD_WORDS);
    localparam logic [FREE_W-1:0]        PKT_WORDS = FREE_W'(PAYLOAD_WORDS + 2);
    localparam logic [FREE_W-1:0]        DEPTH     = FREE_W'(FIFO_DEPTH);
    localparam logic [HDR_PAYLOAD_W-1:0] LEN_BYTES = HDR_PAYLOAD_W'(4 * PAYLOAD_WORDS);
    localparam logic [HDR_CHAN_W-1:0]    CHAN_NUM  = HDR_CHAN_W'(CHANNEL);

    pkt_state_t  state;
    logic [CNT_W-1:0] count;
    logic        ovr_pending;
    logic        sob_pending;
    iq_sample_t  hold;
    logic [31:0] ts_latch;

    logic [FREE_W-1:0] free_words_c;
    logic              space_ok_c;
    logic [CNT_W-1:0]  count_inc_c;
    iq_sample_t        sample_c;
    logic [31:0]       header_c;
    logic              unused_rssi_hi;

    // Free space is computed one bit wider than fifo_used so a full-depth FIFO cannot wrap
    assign free_words_c = DEPTH - {1'b0, fifo_used};
    assign space_ok_c   = (free_words_c >= PKT_WORDS);
    assign count_inc_c  = count + CNT_W'(1);
    assign sample_c     = '{q: rx_q, i: rx_i};
    assign header_c     = make_header(ovr_pending, sob_pending, CHAN_NUM,
                                      rssi[HDR_RSSI_W-1:0], LEN_BYTES);
    assign unused_rssi_hi = ^rssi[31:HDR_RSSI_W];

    always_ff @(posedge rx_clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            ovr_pending <= 1'b0;
            sob_pending <= 1'b1;
            hold        <= '0;
            ts_latch    <= '0;
            wrreq       <= 1'b0;
            wrdata      <= '0;
            overrun     <= 1'b0;
        end else begin
            wrreq   <= 1'b0;
            overrun <= 1'b0;

            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (!enable) begin
                        sob_pending <= 1'b1;
                    end else if (rx_strobe) begin
                        if (space_ok_c) begin
                            hold     <= sample_c;
                            ts_latch <= timestamp_clock;
                            wrreq    <= 1'b1;
                            wrdata   <= header_c;
                            state    <= ST_TIMESTAMP;
                        end else begin
                            overrun     <= 1'b1;
                            ovr_pending <= 1'b1;
                        end
                    end
                end

                ST_TIMESTAMP: begin
                    wrreq  <= 1'b1;
                    wrdata <= ts_latch;
                    state  <= ST_FIRST;
                end

                ST_FIRST: begin
                    wrreq       <= 1'b1;
                    wrdata      <= hold;
                    count       <= CNT_W'(1);
                    ovr_pending <= 1'b0;
                    sob_pending <= 1'b0;
                    state       <= (LAST_CNT == CNT_W'(1)) ? ST_IDLE : ST_DATA;
                end

                ST_DATA: begin
                    if (!enable) begin
                        state <= ST_PAD;
                    end else if (rx_strobe) begin
                        wrreq  <= 1'b1;
                        wrdata <= sample_c;
                        count  <= count_inc_c;
                        if (count_inc_c == LAST_CNT) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                // Fill the remainder with zeros so every packet has full length
                ST_PAD: begin
                    wrreq  <= 1'b1;
                    wrdata <= '0;
                    count  <= count_inc_c;
                    if (count_inc_c == LAST_CNT) begin
                        sob_pending <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign debug = {7'd0, wrreq, overrun, 3'(state), enable, rx_strobe, rx_clock};

endmodule

// File: tb/tb_chan_fifo_writer.sv
// Directed bench for chan_fifo_writer with a 4-word payload; channel 0 and channel 5 instances.
module tb_chan_fifo_writer;

    localparam int unsigned PW    = 4;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned UW    = 9;

    logic          rx_clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          rx_strobe = 1'b0;
    logic [15:0]   rx_i = '0;
    logic [15:0]   rx_q = '0;
    logic [31:0]   timestamp_clock = '0;
    logic [31:0]   rssi = '0;
    logic [UW-1:0] fifo_used = '0;

    logic          wrreq, overrun, wrreq5, overrun5;
    logic [31:0]   wrdata, wrdata5;
    logic [14:0]   debug, debug5;

    chan_fifo_writer #(.PAYLOAD_WORDS(PW), .FIFO_DEPTH(DEPTH), .USEDW_W(UW), .CHANNEL(0)) dut (
        .rx_clock(rx_clock), .reset(reset), .enable(enable), .rx_strobe(rx_strobe),
        .rx_i(rx_i), .rx_q(rx_q), .timestamp_clock(timestamp_clock), .rssi(rssi),
        .fifo_used(fifo_used), .wrreq(wrreq), .wrdata(wrdata), .overrun(overrun),
        .debug(debug)
    );

    chan_fifo_writer #(.PAYLOAD_WORDS(PW), .FIFO_DEPTH(DEPTH), .USEDW_W(UW), .CHANNEL(5)) dut5 (
        .rx_clock(rx_clock), .reset(reset), .enable(enable), .rx_strobe(rx_strobe),
        .rx_i(rx_i), .rx_q(rx_q), .timestamp_clock(timestamp_clock), .rssi(rssi),
        .fifo_used(fifo_used), .wrreq(wrreq5), .wrdata(wrdata5), .overrun(overrun5),
        .debug(debug5)
    );

    always #5 rx_clock = ~rx_clock;

    int cyc = 0;
    always @(posedge rx_clock) cyc <= cyc + 1;

    logic [31:0] wq_d[$];
    int          wq_c[$];
    logic [31:0] w5_d[$];
    int          ovr_c[$];

    always @(negedge rx_clock) begin
        if (wrreq) begin
            wq_d.push_back(wrdata);
            wq_c.push_back(cyc);
        end
        if (wrreq5) w5_d.push_back(wrdata5);
        if (overrun) ovr_c.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] qd(input int k);
        return (k < int'(wq_d.size())) ? wq_d[k] : 32'hxxxx_xxxx;
    endfunction

    function automatic int qc(input int k);
        return (k < int'(wq_c.size())) ? wq_c[k] : -1000;
    endfunction

    function automatic logic [31:0] q5(input int k);
        return (k < int'(w5_d.size())) ? w5_d[k] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_q();
        wq_d.delete();
        wq_c.delete();
        w5_d.delete();
        ovr_c.delete();
    endtask

    // One-cycle strobe at the current cycle, then three quiet cycles
    task automatic strobe(input logic [15:0] i, input logic [15:0] q, output int t);
        rx_i      = i;
        rx_q      = q;
        rx_strobe = 1'b1;
        t         = cyc;
        @(negedge rx_clock);
        rx_strobe = 1'b0;
        repeat (3) @(negedge rx_clock);
    endtask

    task automatic send_pkt();
        int t;
        for (int k = 0; k < int'(PW); k++) begin
            strobe(16'(16'h0100 + k), 16'(16'h0200 + k), t);
        end
        repeat (3) @(negedge rx_clock);
    endtask

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [31:0] ts;
    } stim_t;

    typedef struct {
        logic [31:0] word;
        int          dt;
    } exp_t;

    stim_t stim[4];
    exp_t  exp1[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t0, tb;

        stim[0] = '{16'h0001, 16'h0002, 32'd100};
        stim[1] = '{16'h0003, 16'h0004, 32'd200};
        stim[2] = '{16'h0005, 16'h0006, 32'd300};
        stim[3] = '{16'h0007, 16'h0008, 32'd400};
        exp1[0] = '{32'h1000_0010, 1};
        exp1[1] = '{32'h0000_0064, 2};
        exp1[2] = '{32'h0002_0001, 3};
        exp1[3] = '{32'h0004_0003, 5};
        exp1[4] = '{32'h0006_0005, 9};
        exp1[5] = '{32'h0008_0007, 13};

        // Reset values
        repeat (3) @(negedge rx_clock);
        chk("rst_wrreq", 32'(wrreq), 32'd0);
        chk("rst_wrdata", wrdata, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_debug", 32'(debug), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge rx_clock);

        // Test 1: four strobes into an empty FIFO
        clear_q();
        t0 = 0;
        for (int k = 0; k < 4; k++) begin
            timestamp_clock = stim[k].ts;
            strobe(stim[k].i, stim[k].q, t);
            if (k == 0) t0 = t;
        end
        repeat (3) @(negedge rx_clock);
        chk("t1_count", 32'(wq_d.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_word%0d", k), qd(k), exp1[k].word);
            chk($sformatf("t1_cycle%0d", k), 32'(qc(k) - t0), 32'(exp1[k].dt));
        end
        chk("t1_idle", 32'(debug[5:3]), 32'd0);

        // Test 2: not enough room for 6 words -> drop and flag
        fifo_used = UW'(DEPTH - 5);
        clear_q();
        strobe(16'h1111, 16'h2222, t);
        chk("t2_no_write", 32'(wq_d.size()), 32'd0);
        chk("t2_ovr_count", 32'(ovr_c.size()), 32'd1);
        chk("t2_ovr_cycle", 32'((ovr_c.size() > 0) ? ovr_c[0] - t : -1), 32'd1);
        fifo_used = '0;
        clear_q();
        send_pkt();
        chk("t2_count", 32'(wq_d.size()), 32'd6);
        chk("t2_hdr_ovr", qd(0), 32'h8000_0010);

        // Test 3: back-to-back packet, then an enable toggle
        clear_q();
        send_pkt();
        chk("t3_hdr_cont", qd(0), 32'h0000_0010);
        enable = 1'b0;
        repeat (2) @(negedge rx_clock);
        enable = 1'b1;
        @(negedge rx_clock);
        clear_q();
        send_pkt();
        chk("t3_hdr_sob", qd(0), 32'h1000_0010);

        // Test 4: enable drops after two samples -> two zero pad words
        clear_q();
        strobe(16'h00a1, 16'h00b1, t);
        strobe(16'h00a2, 16'h00b2, tb);
        enable = 1'b0;
        repeat (5) @(negedge rx_clock);
        chk("t4_count", 32'(wq_d.size()), 32'd6);
        chk("t4_sample1", qd(3), 32'h00b2_00a2);
        chk("t4_pad0", qd(4), 32'd0);
        chk("t4_pad1", qd(5), 32'd0);
        chk("t4_pad_cycle", 32'(qc(4) - tb), 32'd6);
        chk("t4_pad_consec", 32'(qc(5) - qc(4)), 32'd1);
        chk("t4_idle", 32'(debug[5:3]), 32'd0);

        // Test 5: reset during TIMESTAMP discards the packet and clears pending flags
        enable    = 1'b1;
        fifo_used = UW'(DEPTH - 5);
        strobe(16'h3333, 16'h4444, t);
        fifo_used = '0;
        clear_q();
        rx_i      = 16'h5555;
        rx_q      = 16'h6666;
        rx_strobe = 1'b1;
        @(negedge rx_clock);
        rx_strobe = 1'b0;
        chk("t5_in_ts_state", 32'(debug[5:3]), 32'd1);
        reset = 1'b1;
        @(negedge rx_clock);
        chk("t5_rst_wrreq", 32'(wrreq), 32'd0);
        chk("t5_rst_state", 32'(debug[5:3]), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge rx_clock);
        chk("t5_partial_count", 32'(wq_d.size()), 32'd1);
        chk("t5_partial_hdr", qd(0), 32'h9000_0010);
        clear_q();
        send_pkt();
        chk("t5_count", 32'(wq_d.size()), 32'd6);
        chk("t5_hdr_clean", qd(0), 32'h1000_0010);

        // Test 6: channel and RSSI fields
        rssi = 32'hFFFF_FFEA;
        clear_q();
        send_pkt();
        chk("t6_hdr_ch0", qd(0), 32'h0000_5410);
        chk("t6_hdr_ch5", q5(0), 32'h0005_5410);
        chk("t6_count_ch5", 32'(w5_d.size()), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
